// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and FSM state type for the memory responder.
package mem_pkg;
    localparam int AW_DEF = 13;
    localparam int DW_DEF = 8;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port storage, synchronous write, asynchronous read, no reset.
module mem_array #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
    assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory slave with one-cycle response pulse and saturating access counters.
import mem_pkg::*;
module mem_responder #(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int WAIT_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic          resp_valid,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [15:0]   rd_count,
    output logic [15:0]   wr_count
);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);
    state_t        state;
    logic [3:0]    cnt;
    logic          op_wr;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] mem_rd;
    logic [AW-1:0] mem_addr;
    logic          accept;
    logic [15:0]   rd_cnt;
    logic [15:0]   wr_cnt;
    assign accept   = (state == IDLE) && (mem_read ^ mem_write);
    // The single port sees the live address while idle so a zero-wait read can capture immediately.
    assign mem_addr = (state == IDLE) ? addr : addr_q;
    assign rd_count = rd_cnt;
    assign wr_count = wr_cnt;
    mem_array #(.AW(AW), .DW(DW)) u_array (
        .clk   (clk),
        .we    (state == RESP && op_wr),
        .addr  (mem_addr),
        .wdata (wdata_q),
        .rdata (mem_rd)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_wr      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready      <= 1'b1;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
        end else begin
            resp_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read && mem_write) begin
                        err <= 1'b1;
                    end else if (accept) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        op_wr   <= mem_write;
                        ready   <= 1'b0;
                        if (WAIT_CYC == 0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            if (mem_read) rdata <= mem_rd;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        if (!op_wr) rdata <= mem_rd;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    if (op_wr) wr_cnt <= (wr_cnt == CNT_MAX) ? wr_cnt : wr_cnt + 16'd1;
                    else       rd_cnt <= (rd_cnt == CNT_MAX) ? rd_cnt : rd_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized accesses on a zero-wait and a two-wait instance against a behavioural model.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read   [2];
    logic        mem_write  [2];
    logic [12:0] addr       [2];
    logic [7:0]  wdata      [2];
    logic        ready      [2];
    logic        resp_valid [2];
    logic        err        [2];
    logic [7:0]  rdata      [2];
    logic [15:0] rd_count   [2];
    logic [15:0] wr_count   [2];

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  mdl [int];
    int          exp_rd [2];
    int          exp_wr [2];
    logic [7:0]  exp_rdata [2];
    logic [12:0] pool [16];

    always #5 clk = ~clk;

    mem_responder #(.AW(13), .DW(8), .WAIT_CYC(0)) u_w0 (
        .clk(clk), .rst(rst), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]), .resp_valid(resp_valid[0]),
        .rdata(rdata[0]), .err(err[0]), .rd_count(rd_count[0]), .wr_count(wr_count[0])
    );
    mem_responder #(.AW(13), .DW(8), .WAIT_CYC(2)) u_w2 (
        .clk(clk), .rst(rst), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]), .resp_valid(resp_valid[1]),
        .rdata(rdata[1]), .err(err[1]), .rd_count(rd_count[1]), .wr_count(wr_count[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic check_idle(input int i);
        check("resp_idle", resp_valid[i], 1'b0);
        check("ready_idle", ready[i], 1'b1);
        check("rd_count", rd_count[i], exp_rd[i]);
        check("wr_count", wr_count[i], exp_wr[i]);
        check("rdata_hold", rdata[i], exp_rdata[i]);
    endtask

    // One complete access; poke drives junk requests while the block is busy.
    task automatic access(input int i, input bit wr, input logic [12:0] a, input logic [7:0] d, input bit poke);
        int k;
        int w;
        int key;
        w = (i == 0) ? 0 : 2;
        key = i * 8192 + int'(a);
        @(negedge clk);
        check("ready_pre", ready[i], 1'b1);
        mem_read[i] = !wr; mem_write[i] = wr; addr[i] = a; wdata[i] = d;
        @(negedge clk);
        mem_read[i] = 1'b0; mem_write[i] = 1'b0;
        addr[i] = 13'($urandom); wdata[i] = 8'($urandom);
        k = 1;
        while (!resp_valid[i] && k < 20) begin
            check("ready_busy", ready[i], 1'b0);
            if (poke) begin
                mem_read[i] = 1'($urandom); mem_write[i] = 1'($urandom); addr[i] = 13'($urandom);
            end
            @(negedge clk);
            k++;
        end
        check("latency", k, w + 1);
        check("ready_resp", ready[i], 1'b0);
        check("err_resp", err[i], 1'b0);
        mem_read[i] = 1'b0; mem_write[i] = 1'b0;
        if (wr) begin
            mdl[key] = d;
            exp_wr[i] = sat_inc(exp_wr[i]);
        end else begin
            check("rdata", rdata[i], mdl[key]);
            exp_rdata[i] = mdl[key];
            exp_rd[i] = sat_inc(exp_rd[i]);
        end
        @(negedge clk);
        check_idle(i);
    endtask

    task automatic err_test(input int i);
        @(negedge clk);
        mem_read[i] = 1'b1; mem_write[i] = 1'b1; addr[i] = 13'($urandom);
        @(negedge clk);
        check("err_pulse", err[i], 1'b1);
        check("err_ready", ready[i], 1'b1);
        check("err_noresp", resp_valid[i], 1'b0);
        mem_read[i] = 1'b0; mem_write[i] = 1'b0;
        @(negedge clk);
        check("err_clear", err[i], 1'b0);
        check_idle(i);
    endtask

    initial begin
        int i;
        int r;
        rst = 1'b1;
        for (int j = 0; j < 2; j++) begin
            mem_read[j] = 1'b0; mem_write[j] = 1'b0; addr[j] = '0; wdata[j] = '0;
            exp_rd[j] = 0; exp_wr[j] = 0; exp_rdata[j] = '0;
        end
        pool[0] = 13'h0000; pool[1] = 13'h1FFF; pool[2] = 13'h0010; pool[3] = 13'h0020;
        pool[4] = 13'h0030;  pool[5] = 13'h1FFE; pool[6] = 13'h0001; pool[7] = 13'h1000;
        for (int j = 8; j < 16; j++) pool[j] = 13'($urandom);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 2; j++) begin
            check("rst_err", err[j], 1'b0);
            check_idle(j);
        end
        // Two-wait write then read of the same word.
        access(1, 1'b1, 13'h0010, 8'hA5, 1'b0);
        access(1, 1'b0, 13'h0010, 8'h00, 1'b0);
        check("wr_one", wr_count[1], 16'd1);
        check("rd_one", rd_count[1], 16'd1);
        // Zero-wait reads at the address extremes.
        access(0, 1'b1, 13'h0000, 8'h11, 1'b0);
        access(0, 1'b1, 13'h1FFF, 8'h22, 1'b0);
        access(0, 1'b0, 13'h0000, 8'h00, 1'b0);
        access(0, 1'b0, 13'h1FFF, 8'h00, 1'b0);
        err_test(0);
        err_test(1);
        // Reset during WAIT aborts a pending write.
        access(1, 1'b1, 13'h0020, 8'h00, 1'b0);
        @(negedge clk);
        mem_write[1] = 1'b1; addr[1] = 13'h0020; wdata[1] = 8'h3C;
        @(negedge clk);
        mem_write[1] = 1'b0;
        check("abort_busy", ready[1], 1'b0);
        rst = 1'b1;
        #1;
        check("abort_ready", ready[1], 1'b1);
        check("abort_wr", wr_count[1], 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 2; j++) begin
            exp_rd[j] = 0; exp_wr[j] = 0; exp_rdata[j] = '0;
        end
        @(negedge clk);
        check_idle(0);
        check_idle(1);
        access(1, 1'b0, 13'h0020, 8'h00, 1'b0);
        check("abort_data", rdata[1], 8'h00);
        // Requests raised in WAIT are dropped.
        access(1, 1'b1, 13'h0030, 8'h5A, 1'b1);
        for (int j = 0; j < 16; j++) begin
            access(0, 1'b1, pool[j], 8'($urandom), 1'b0);
            access(1, 1'b1, pool[j], 8'($urandom), 1'b0);
        end
        for (int n = 0; n < 300; n++) begin
            i = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r == 0) err_test(i);
            else access(i, r < 5, pool[$urandom_range(0, 15)], 8'($urandom), 1'($urandom));
        end
        // Saturation of the read counter.
        @(negedge clk);
        force u_w2.rd_cnt = 16'hFFFE;
        @(negedge clk);
        release u_w2.rd_cnt;
        exp_rd[1] = 16'hFFFE;
        repeat (3) access(1, 1'b0, pool[$urandom_range(0, 15)], 8'h00, 1'b0);
        check("rd_sat", rd_count[1], 16'hFFFF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
